axis_adc_acq_sequencer: RTL and testbench

Acquisition sequencer placed between the Red Pitaya ADC stream front-end and the downstream capture FIFO/DMA. It owns the ADC channel-select lines. It discards settling samples after a channel-mode change, waits for a trigger, then waits a programmable sample delay. It then forwards exactly a programmed number of samples on an AXI4-Stream master with TLAST on the final one. The ADC source cannot stall, so downstream back-pressure is absorbed by one output register, and lost samples are flagged.

---
 rtl/axis_adc_acq_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_axis_adc_acq_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_adc_acq_sequencer.sv
// rtl/axis_adc_acq_sequencer.sv - ADC acquisition sequencer: settle, trigger, delay, counted AXIS capture
//
// Sits between the ADC stream front-end and the capture FIFO/DMA and owns the
// ADC channel-select lines. Optional build macro: ACQ_SEQ_DECIM_EN adds
// cfg_decim and keeps only every (cfg_decim+1)-th sample during capture.
//
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   cfg_mode/cfg_delay/cfg_count      configuration, latched on start
//   cfg_decim                         decimation factor (ACQ_SEQ_DECIM_EN only)
//   start, trig, abort                single-cycle control pulses
//   adc_channel_switch                ADC front-end channel select
//   s_axis_tvalid/tdata               ADC sample stream (cannot stall)
//   m_axis_tvalid/tready/tlast/tdata  capture stream, single output register
//   sts_busy, sts_done, sts_overflow  status: not idle, done pulse, sticky drop

module axis_adc_acq_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 32,
    parameter int SETTLE_SAMPLES   = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [1:0]                  cfg_mode,
    input  logic [CNT_WIDTH-1:0]        cfg_delay,
    input  logic [CNT_WIDTH-1:0]        cfg_count,
`ifdef ACQ_SEQ_DECIM_EN
    input  logic [15:0]                 cfg_decim,
`endif
    input  logic                        start,
    input  logic                        trig,
    input  logic                        abort,
    output logic [1:0]                  adc_channel_switch,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic                        sts_overflow
);

    localparam int SW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, ARMED, DELAY, CAPTURE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] delay_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [SW-1:0]        settle_cnt;
    logic                 skip_settle;
    logic                 take;
    logic                 is_last;

`ifdef ACQ_SEQ_DECIM_EN
    logic [15:0] decim_q;
    logic [15:0] decim_cnt;
    // Phase 0 of the decimation counter is the kept sample, so the first
    // sample after trigger/delay is always taken.
    assign take = (decim_cnt == 16'd0);
`else
    assign take = 1'b1;
`endif

    // Only meaningful while count_q != 0.
    assign is_last = (cnt == count_q - CNT_ONE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state              <= IDLE;
            delay_q            <= '0;
            count_q            <= '0;
            cnt                <= '0;
            settle_cnt         <= '0;
            skip_settle        <= 1'b0;
            adc_channel_switch <= 2'b11;
            m_axis_tvalid      <= 1'b0;
            m_axis_tlast       <= 1'b0;
            m_axis_tdata       <= '0;
            sts_busy           <= 1'b0;
            sts_done           <= 1'b0;
            sts_overflow       <= 1'b0;
`ifdef ACQ_SEQ_DECIM_EN
            decim_q            <= '0;
            decim_cnt          <= '0;
`endif
        end else begin
            sts_done <= 1'b0;

            // Output register drains independently of the sequencer state so a
            // pending entry survives abort. A load below overrides this.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end

            if (abort) begin
                state    <= IDLE;
                sts_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            delay_q            <= cfg_delay;
                            count_q            <= cfg_count;
                            adc_channel_switch <= cfg_mode;
                            sts_overflow       <= 1'b0;
                            sts_busy           <= 1'b1;
                            settle_cnt         <= '0;
                            // No switch happens when the mode is unchanged, so
                            // there is nothing to settle.
                            skip_settle        <= (cfg_mode == adc_channel_switch) ||
                                                  (SETTLE_SAMPLES == 0);
`ifdef ACQ_SEQ_DECIM_EN
                            decim_q            <= cfg_decim;
`endif
                            state              <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (skip_settle) begin
                            state <= ARMED;
                        end else if (s_axis_tvalid) begin
                            if (settle_cnt == SETTLE_LAST)
                                state <= ARMED;
                            else
                                settle_cnt <= settle_cnt + SETTLE_ONE;
                        end
                    end
                    ARMED: begin
                        if (trig) begin
                            cnt   <= '0;
`ifdef ACQ_SEQ_DECIM_EN
                            decim_cnt <= '0;
`endif
                            state <= (delay_q != '0) ? DELAY : CAPTURE;
                        end
                    end
                    DELAY: begin
                        if (s_axis_tvalid) begin
                            if (cnt == delay_q - CNT_ONE) begin
                                cnt   <= '0;
                                state <= CAPTURE;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (count_q == '0) begin
                            sts_done <= 1'b1;
                            sts_busy <= 1'b0;
                            state    <= IDLE;
                        end else if (s_axis_tvalid && take) begin
                            cnt <= cnt + CNT_ONE;
                            if (!m_axis_tvalid || m_axis_tready) begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= s_axis_tdata;
                                m_axis_tlast  <= is_last;
                            end else begin
                                // Source cannot stall: drop, but keep counting.
                                sts_overflow <= 1'b1;
                            end
                            if (is_last) begin
                                sts_done <= 1'b1;
                                sts_busy <= 1'b0;
                                state    <= IDLE;
                            end
                        end
`ifdef ACQ_SEQ_DECIM_EN
                        if (s_axis_tvalid)
                            decim_cnt <= (decim_cnt == decim_q) ? 16'd0 : decim_cnt + 16'd1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_adc_acq_sequencer.sv
// tb/tb_axis_adc_acq_sequencer.sv - self-checking bench for axis_adc_acq_sequencer

module tb_axis_adc_acq_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_count;
    logic        start, trig, abort;
    logic [1:0]  adc_channel_switch;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        sts_busy, sts_done, sts_overflow;

    axis_adc_acq_sequencer #(
        .AXIS_TDATA_WIDTH(32), .CNT_WIDTH(32), .SETTLE_SAMPLES(2)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_count(cfg_count),
        .start(start), .trig(trig), .abort(abort),
        .adc_channel_switch(adc_channel_switch),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_overflow(sts_overflow)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: every valid sample presented after the trigger cycle,
    // in order. A capture of delay D, count C must emit post[D .. D+C-1].
    logic [31:0] post[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          done_cnt;
    logic        done_last;
    logic        rec = 1'b0;
    int          vrate = 100;
    logic [31:0] ramp = 32'd0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [31:0] prev_d = 32'd0;

    typedef struct {
        logic [1:0] mode;
        int         delay;
        int         count;
        bit         hold;       // tready held low for the whole capture
        int         exp_beats;
        bit         exp_ovf;
        bit         exp_last;   // tlast present alongside sts_done
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, drive the next sample
    // shortly after the rising edge.
    task automatic cycle();
        @(negedge aclk);
        if (prev_v && !prev_r)
            chk("hold_stable", {30'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                {30'd0, 1'b1, prev_l, prev_d});
        if (m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
        end
        if (sts_done) begin
            done_cnt++;
            done_last = m_axis_tlast;
        end
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
        @(posedge aclk);
        #1;
        start = 1'b0;
        trig  = 1'b0;
        abort = 1'b0;
        s_axis_tdata  = ramp;
        ramp          = ramp + 32'd1;
        s_axis_tvalid = ($urandom_range(99) < vrate);
        if (rec && s_axis_tvalid)
            post.push_back(s_axis_tdata);
    endtask

    task automatic clear_obs();
        post.delete();
        got_d.delete();
        got_l.delete();
        done_cnt  = 0;
        done_last = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] mode, input int d, input int c);
        cfg_mode  = mode;
        cfg_delay = d;
        cfg_count = c;
        start     = 1'b1;
        cycle();
        chk("start_switch", 64'(adc_channel_switch), 64'(mode));
        chk("start_busy", 64'(sts_busy), 64'd1);
        chk("start_ovf_clear", 64'(sts_overflow), 64'd0);
        vrate = 100;
        repeat (8) cycle();
    endtask

    task automatic run_seq(input logic [1:0] mode, input int d, input int c, input bit hold,
                           input int exp_beats, input bit exp_ovf, input bit exp_last,
                           input int rate);
        int n;
        clear_obs();
        m_axis_tready = !hold;
        do_start(mode, d, c);
        vrate = rate;
        trig  = 1'b1;
        rec   = 1'b1;
        cycle();
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            cycle();
            n++;
        end
        repeat (4) cycle();
        rec = 1'b0;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("overflow", 64'(sts_overflow), 64'(exp_ovf));
        chk("tlast_with_done", 64'(done_last), 64'(exp_last));
        if (hold) begin
            m_axis_tready = 1'b1;
            repeat (3) cycle();
        end
        chk("busy_end", 64'(sts_busy), 64'd0);
        chk("beats", 64'(got_d.size()), 64'(exp_beats));
        for (int i = 0; i < got_d.size(); i++) begin
            if (d + i < post.size())
                chk("beat_data", 64'(got_d[i]), 64'(post[d + i]));
            else
                chk("beat_in_model", 64'(i), 64'(post.size() - d));
            chk("beat_last", 64'(got_l[i]), 64'(i == c - 1));
        end
    endtask

    initial begin
        vecs[0] = '{2'b01, 0, 4, 1'b0, 4, 1'b0, 1'b1};
        vecs[1] = '{2'b01, 3, 2, 1'b0, 2, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 0, 5, 1'b1, 1, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 2, 0, 1'b0, 0, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 0, 1, 1'b1, 1, 1'b0, 1'b1};

        areset = 1'b1;
        cfg_mode = 2'b00; cfg_delay = 32'd0; cfg_count = 32'd0;
        start = 1'b0; trig = 1'b0; abort = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_switch", 64'(adc_channel_switch), 64'd3);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_busy", 64'(sts_busy), 64'd0);
        chk("rst_flags", 64'({sts_done, sts_overflow}), 64'd0);
        areset = 1'b0;
        cycle();

        // Directed table.
        foreach (vecs[v])
            run_seq(vecs[v].mode, vecs[v].delay, vecs[v].count, vecs[v].hold,
                    vecs[v].exp_beats, vecs[v].exp_ovf, vecs[v].exp_last, 100);

        // Abort during DELAY.
        clear_obs();
        m_axis_tready = 1'b1;
        do_start(2'b10, 5, 3);
        trig = 1'b1;
        cycle();
        repeat (2) cycle();
        abort = 1'b1;
        cycle();
        chk("abort_delay_busy", 64'(sts_busy), 64'd0);
        repeat (12) cycle();
        chk("abort_delay_beats", 64'(got_d.size()), 64'd0);
        chk("abort_delay_done", 64'(done_cnt), 64'd0);
        chk("abort_keeps_switch", 64'(adc_channel_switch), 64'd2);

        // Abort coincident with trig in ARMED.
        clear_obs();
        do_start(2'b01, 0, 3);
        trig  = 1'b1;
        abort = 1'b1;
        cycle();
        chk("abort_trig_busy", 64'(sts_busy), 64'd0);
        repeat (12) cycle();
        chk("abort_trig_beats", 64'(got_d.size()), 64'd0);
        chk("abort_trig_done", 64'(done_cnt), 64'd0);

        // Randomized captures with gappy input against the queue model.
        for (int r = 0; r < 10; r++) begin
            logic [1:0] m;
            int d, c;
            m = 2'($urandom_range(1, 3));
            d = $urandom_range(0, 5);
            c = $urandom_range(0, 8);
            run_seq(m, d, c, 1'b0, c, 1'b0, (c > 0), 75);
        end

        // Asynchronous reset in the middle of a stalled capture.
        clear_obs();
        m_axis_tready = 1'b0;
        do_start(2'b10, 0, 20);
        trig = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("pre_reset_ovf", 64'(sts_overflow), 64'd1);
        #2;
        areset = 1'b1;
        prev_v = 1'b0;
        #1;
        chk("arst_switch", 64'(adc_channel_switch), 64'd3);
        chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("arst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("arst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("arst_status", 64'({sts_busy, sts_done, sts_overflow}), 64'd0);
        cycle();
        areset = 1'b0;
        m_axis_tready = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
